// File: rtl/radix4_booth_seq_mult.sv
// radix4_booth_seq_mult: iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Define RADIX4_EARLY_TERM_EN to finish as soon as the remaining multiplier digits are all zero.
module radix4_booth_seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int P  = 2 * WIDTH;
    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [P-1:0]     acc, mcand, pp, prod;
    logic [WIDTH+2:0] m;
    logic [CW-1:0]    cnt;
    logic [WIDTH+1:0] ext_a, ext_b;
    logic             last;

    // Two extra bits keep the most-negative and unsigned all-ones cases exact.
    assign ext_a   = {{2{in_signed & a[WIDTH-1]}}, a};
    assign ext_b   = {{2{in_signed & b[WIDTH-1]}}, b};
    assign product = prod;

    assign pp = (m[2:0] == 3'b001 || m[2:0] == 3'b010) ? mcand :
                (m[2:0] == 3'b011)                     ? mcand << 1 :
                (m[2:0] == 3'b100)                     ? -(mcand << 1) :
                (m[2:0] == 3'b101 || m[2:0] == 3'b110) ? -mcand : '0;

`ifdef RADIX4_EARLY_TERM_EN
    assign last = (cnt == CW'(N - 1)) || (m == '0) || (&m);
`else
    assign last = cnt == CW'(N - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready  = 1'b1;
                busy      = 1'b0;
                state_nxt = in_valid ? BUSY : IDLE;
            end
            BUSY:    state_nxt = last ? DONE : BUSY;
            DONE: begin
                out_valid = 1'b1;
                state_nxt = out_ready ? IDLE : DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            m     <= '0;
            cnt   <= '0;
            prod  <= '0;
        end else if (state == IDLE && in_valid) begin
            acc   <= '0;
            mcand <= {{(WIDTH-2){ext_a[WIDTH+1]}}, ext_a};
            m     <= {ext_b, 1'b0};
            cnt   <= '0;
        end else if (state == BUSY) begin
            acc   <= acc + pp;
            mcand <= mcand << 2;
            m     <= {{2{m[WIDTH+2]}}, m[WIDTH+2:2]};
            cnt   <= cnt + 1'b1;
            if (last) prod <= acc + pp;
        end
    end
endmodule

// File: tb/tb_radix4_booth_seq_mult.sv
// tb_radix4_booth_seq_mult: directed checks of the 32-bit Booth multiplier against hand-computed products.
module tb_radix4_booth_seq_mult;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_signed, out_valid, out_ready, busy;
    logic [31:0] a, b;
    logic [63:0] product;
    int          passed = 0;
    int          total  = 0;

    radix4_booth_seq_mult #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic s, input logic [63:0] exp, input int lat, input int hold);
        int n;
        @(negedge clk);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_v;
        in_signed = s;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (lat >= 0) check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " product"}, product, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold product"}, product, exp);
            check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " post valid"}, 64'(out_valid), 64'd0);
        check({tag, " post in_ready"}, 64'(in_ready), 64'd1);
        check({tag, " post product"}, product, exp);
    endtask

    initial begin
        int fix;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset product", product, 64'd0);
        rst_n = 1'b1;
`ifdef RADIX4_EARLY_TERM_EN
        fix = -1;
`else
        fix = 17;
`endif
        run_op("5x-7 s", 32'd5, 32'hFFFF_FFF9, 1'b1, 64'hFFFF_FFFF_FFFF_FFDD, fix, 0);
        run_op("ones u", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, fix, 5);
        run_op("ones s", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, fix, 0);
        run_op("minneg s", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, fix, 0);
        run_op("minneg u", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, fix, 0);
        run_op("7xmax s", 32'd7, 32'h7FFF_FFFF, 1'b1, 64'h0000_0003_7FFF_FFF9, fix, 0);
        run_op("minxmax s", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000, fix, 0);
`ifdef RADIX4_EARLY_TERM_EN
        run_op("10x1 early", 32'd10, 32'd1, 1'b1, 64'd10, 2, 0);
        run_op("11x0 early", 32'd11, 32'd0, 1'b1, 64'd0, 1, 0);
`else
        run_op("10x1", 32'd10, 32'd1, 1'b1, 64'd10, 17, 0);
        run_op("11x0", 32'd11, 32'd0, 1'b1, 64'd0, 17, 0);
`endif
        @(negedge clk);
        in_valid  = 1'b1;
        a         = 32'hFFFF_FFF4;
        b         = 32'hFFFF_FFFC;
        in_signed = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("abort busy before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort in_ready", 64'(in_ready), 64'd1);
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort no valid", 64'(out_valid), 64'd0);
        run_op("-9x5 s", 32'hFFFF_FFF7, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFD3, fix, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
